shared_ram_arb: RTL

- Parametrised synchronous data memory shared by NPORTS requesters (one per core in the dual-core build).
- Replaces the asynchronous chip-enable RAM.
- Single-port storage array behind a round-robin arbiter, with a req/ack handshake per port.
- After reset, a hardware clear sequence zeroes every word before any request is served.

---
 rtl/shared_ram_arb_if.sv | 18 +
 rtl/shared_ram_arb.sv | 112 +++++++++++
 2 files changed

// File: rtl/shared_ram_arb_if.sv
// Request/ack bus between the requester cores and the shared data RAM.
// Per-port fields are flattened: port k uses slice [k*W +: W].
interface shared_ram_arb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NPORTS = 2
);
    logic [NPORTS-1:0]        req;
    logic [NPORTS-1:0]        we;
    logic [NPORTS*ADDR_W-1:0] addr;
    logic [NPORTS*DATA_W-1:0] wdata;
    logic [NPORTS-1:0]        ack;
    logic [NPORTS*DATA_W-1:0] rdata;
    logic                     init_done;

    modport master (output req, we, addr, wdata, input ack, rdata, init_done);
    modport slave  (input req, we, addr, wdata, output ack, rdata, init_done);
endinterface

// File: rtl/shared_ram_arb.sv
// Single-port data RAM shared by NPORTS requesters through a round-robin arbiter.
// A clear sequence zeroes every word after reset before any request is served.
module shared_ram_arb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NPORTS = 2
) (
    input  logic             clock,
    input  logic             nreset,
    shared_ram_arb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int GW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [GW-1:0] LAST_RST = GW'(NPORTS - 1);

    logic [DATA_W-1:0]        mem [DEPTH];

    logic [0:0]               state_q, state_d;
    logic [ADDR_W-1:0]        ptr_q, ptr_d;
    logic                     init_done_q, init_done_d;
    logic [NPORTS-1:0]        ack_q, ack_d;
    logic [NPORTS*DATA_W-1:0] rdata_q, rdata_d;
    logic [GW-1:0]            last_q, last_d;

    logic [NPORTS-1:0]        elig;
    logic                     gnt_vld;
    logic [GW-1:0]            gnt_idx;
    logic                     gnt_we;
    logic [ADDR_W-1:0]        gnt_addr;
    logic [DATA_W-1:0]        gnt_wdata;

    // A port is masked during its own ack cycle so a held req cannot double-issue.
    assign elig = (state_q == ST_RUN) ? (bus.req & ~ack_q) : '0;

    always_comb begin : arb
        int            cand;
        logic [GW-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        idx     = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            cand = (int'(last_q) + i) % NPORTS;
            idx  = GW'(cand);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign gnt_we    = bus.we[gnt_idx];
    assign gnt_addr  = bus.addr[gnt_idx*ADDR_W +: ADDR_W];
    assign gnt_wdata = bus.wdata[gnt_idx*DATA_W +: DATA_W];

    always_comb begin : nxt
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_done_d = init_done_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        last_d      = last_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (&ptr_q) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end else if (gnt_vld) begin
            ack_d[gnt_idx] = 1'b1;
            last_d         = gnt_idx;
            if (!gnt_we) begin
                rdata_d[gnt_idx*DATA_W +: DATA_W] = mem[gnt_addr];
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            ack_q       <= '0;
            rdata_q     <= '0;
            last_q      <= LAST_RST;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            last_q      <= last_d;
        end
    end

    // Storage has no reset; the INIT sweep is what guarantees zeroed contents.
    always_ff @(posedge clock) begin : mem_wr
        if (state_q == ST_INIT) begin
            mem[ptr_q] <= '0;
        end else if (gnt_vld && gnt_we) begin
            mem[gnt_addr] <= gnt_wdata;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.init_done = init_done_q;
endmodule
